// File: rtl/multi_byte_add_sequencer_if.sv
// Operand/result handshake bundle for multi_byte_add_sequencer.
// The master side drives operands and the result accept; the slave side is the adder.
interface multi_byte_add_sequencer_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/multi_byte_add_sequencer.sv
// Byte-serial wide adder: one 8-bit ripple slice per clock, carry chained in a register.
// Define SUBTRACT_EN to build the a - b path (b inverted, carry seeded with 1).
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module multi_byte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input logic                         clk,
    input logic                         rst,
    multi_byte_add_sequencer_if.slave   bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cy;
    logic          r_sub;
    logic [IW-1:0] r_idx;

    logic          w_accept;
    logic          w_run_step;
    logic          w_last;
    logic          w_sub_in;
    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [7:0]    w_b_eff;
    logic [7:0]    w_sum_byte;
    logic [8:0]    w_carry;

    assign w_last   = (r_idx == LAST);
    assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
    assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

`ifdef SUBTRACT_EN
    assign w_sub_in = bus.sub;
    assign w_b_eff  = r_sub ? ~w_b_byte : w_b_byte;
`else
    logic w_unused_sub;
    assign w_sub_in     = 1'b0;
    assign w_b_eff      = w_b_byte;
    assign w_unused_sub = bus.sub ^ r_sub;
`endif

    // Eight-cell ripple slice; carry-in comes from the inter-byte register.
    assign w_carry[0] = r_cy;
    for (genvar g = 0; g < 8; g++) begin : g_fa
        full_adder u_fa (
            .i_a (w_a_byte[g]),
            .i_b (w_b_eff[g]),
            .i_c (w_carry[g]),
            .o_s (w_sum_byte[g]),
            .o_c (w_carry[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_accept      = 1'b0;
        w_run_step    = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy   = 1'b1;
                w_run_step = 1'b1;
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // sum_q keeps stale upper bytes across accepts; every lane is rewritten in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cy  <= 1'b0;
            r_sub <= 1'b0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_sub <= w_sub_in;
            r_cy  <= w_sub_in;
            r_idx <= '0;
        end else if (w_run_step) begin
            r_sum[{r_idx, 3'b000} +: 8] <= w_sum_byte;
            r_cy <= w_carry[8];
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cy;
endmodule

// File: tb/tb_multi_byte_add_sequencer.sv
// Scoreboard bench: a 4-byte instance for the main cases and a 1-byte
// instance for back-to-back throughput.
module tb_multi_byte_add_sequencer;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    logic [32:0] q4[$];
    logic [8:0]  q1[$];

    multi_byte_add_sequencer_if #(.NBYTES(4)) d4 ();
    multi_byte_add_sequencer_if #(.NBYTES(1)) d1 ();

    multi_byte_add_sequencer #(.NBYTES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (d4)
    );

    multi_byte_add_sequencer #(.NBYTES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op4(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] es,
                       input logic ec, input int hold);
        int k;
        int n;
        logic [32:0] e;
        k = 0;
        while (!d4.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 20) check("in_ready_wait", 0, 1);
        d4.a = a;
        d4.b = b;
        d4.sub = s;
        d4.in_valid = 1'b1;
        d4.out_ready = 1'b0;
        @(posedge clk);
        q4.push_back({ec, es});
        #1;
        d4.in_valid = 1'b0;
        d4.a = $urandom;
        d4.b = $urandom;
        check("run_busy", {63'd0, d4.busy}, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!d4.out_valid && n < 20);
        check("latency", n, 4);
        e = (q4.size() != 0) ? q4.pop_front() : 33'h0;
        check("sum", d4.sum, {32'd0, e[31:0]});
        check("carry", {63'd0, d4.carry_out}, {63'd0, e[32]});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_sum", d4.sum, {32'd0, e[31:0]});
            check("hold_in_ready", {63'd0, d4.in_ready}, 0);
            check("hold_valid", {63'd0, d4.out_valid}, 1);
        end
        d4.out_ready = 1'b1;
        @(posedge clk); #1;
        d4.out_ready = 1'b0;
        check("post_in_ready", {63'd0, d4.in_ready}, 1);
        check("post_valid", {63'd0, d4.out_valid}, 0);
    endtask

    initial begin
        int acc_t[2];
        int n_acc;
        int n_res;
        logic acc;
        logic res;
        logic [8:0] e1;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        d4.in_valid = 1'b0; d4.a = '0; d4.b = '0;
        d4.sub = 1'b0; d4.out_ready = 1'b0;
        d1.in_valid = 1'b0; d1.a = '0; d1.b = '0;
        d1.sub = 1'b0; d1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, d4.in_ready}, 1);
        check("rst_out_valid", {63'd0, d4.out_valid}, 0);
        check("rst_sum", d4.sum, 0);
        check("rst_carry", {63'd0, d4.carry_out}, 0);
        check("rst_busy", {63'd0, d4.busy}, 0);
        check("rst_in_ready1", {63'd0, d1.in_ready}, 1);
        rst = 1'b0;

        op4(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 0);
        op4(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 0);
        op4(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 0);
        op4(32'd15, 32'd33, 1'b0, 32'd48, 1'b0, 5);

        // Reset after two RUN edges discards the partial result.
        d4.a = 32'h01010101;
        d4.b = 32'h01010101;
        d4.in_valid = 1'b1;
        @(posedge clk); #1;
        d4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial_sum", d4.sum, 32'h00000202);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", {63'd0, d4.out_valid}, 0);
        check("mid_rst_ready", {63'd0, d4.in_ready}, 1);
        check("mid_rst_busy", {63'd0, d4.busy}, 0);
        check("mid_rst_sum", d4.sum, 0);
        op4(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 0);

`ifdef SUBTRACT_EN
        op4(32'd7, 32'd5, 1'b1, 32'd2, 1'b1, 0);
        op4(32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 0);
`else
        op4(32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 0);
`endif

        // One-byte instance: in_valid and out_ready held high.
        n_acc = 0;
        n_res = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        d1.a = 8'd245;
        d1.b = 8'd3;
        d1.in_valid = 1'b1;
        d1.out_ready = 1'b1;
        for (int t = 0; t < 30 && n_res < 2; t++) begin
            @(negedge clk);
            acc = d1.in_valid && d1.in_ready;
            res = d1.out_valid && d1.out_ready;
            if (res) begin
                e1 = (q1.size() != 0) ? q1.pop_front() : 9'h0;
                check("b2b_sum", {56'd0, d1.sum}, {56'd0, e1[7:0]});
                check("b2b_carry", {63'd0, d1.carry_out}, {63'd0, e1[8]});
                n_res++;
            end
            if (acc) begin
                q1.push_back(n_acc == 0 ? {1'b0, 8'd248} : {1'b1, 8'd0});
                if (n_acc < 2) acc_t[n_acc] = t;
                n_acc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_acc == 1) begin
                    d1.a = 8'd255;
                    d1.b = 8'd1;
                end else begin
                    d1.in_valid = 1'b0;
                end
            end
        end
        check("b2b_results", n_res, 2);
        check("b2b_spacing", acc_t[1] - acc_t[0], 3);
        d1.out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
